// File: rtl/sram_fifo_64x2_if.sv
// sram_fifo_64x2_if: bundles the FIFO's enqueue/dequeue handshakes, its
// occupancy count and the initiator-side SRAM port.
//   slave  : the FIFO controller's view. It receives enq_*, deq_ready and
//            sram_read_data, and drives everything else.
//   master : the surrounding logic plus the SRAM wrapper (the mirror view).
interface sram_fifo_64x2_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 2
);
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_data;
  logic [ADDR_W:0]   count;
  logic              sram_write_en;
  logic [ADDR_W-1:0] sram_write_addr;
  logic [DATA_W-1:0] sram_write_data;
  logic              sram_read_en;
  logic [ADDR_W-1:0] sram_read_addr;
  logic [DATA_W-1:0] sram_read_data;

  modport slave (
    input  enq_valid, enq_data, deq_ready, sram_read_data,
    output enq_ready, deq_valid, deq_data, count,
           sram_write_en, sram_write_addr, sram_write_data,
           sram_read_en, sram_read_addr
  );

  modport master (
    output enq_valid, enq_data, deq_ready, sram_read_data,
    input  enq_ready, deq_valid, deq_data, count,
           sram_write_en, sram_write_addr, sram_write_data,
           sram_read_en, sram_read_addr
  );
endinterface

// File: rtl/sram_fifo_64x2.sv
// sram_fifo_64x2: FIFO controller using an external 1R1W SRAM (DEPTH x DATA_W,
// one-cycle registered read) as its storage. A 2-entry output buffer absorbs
// the read latency, so one element per cycle is sustained. Capacity DEPTH+2.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave view: enq valid/ready/data, deq valid/ready/data, count,
//          SRAM write strobe/addr/data, read strobe/addr, read data in
module sram_fifo_64x2 #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  sram_fifo_64x2_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   sram_cnt_q, sram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] obuf_q [2];
  logic [DATA_W-1:0] obuf_d [2];
  logic              head_q, head_d;
  logic [1:0]        obuf_cnt_q, obuf_cnt_d;

  logic              enq_fire, deq_fire, bypass, wr, rd, push, tail;
  logic [1:0]        occ;
  logic [DATA_W-1:0] push_data;

  assign bus.enq_ready = (sram_cnt_q < DEPTH_C);
  assign bus.deq_valid = (obuf_cnt_q != 2'd0);
  assign bus.deq_data  = obuf_q[head_q];

  // Reset is allowed to be asserted while a producer still offers data;
  // nothing may be written to the SRAM during that time.
  assign enq_fire = bus.enq_valid && bus.enq_ready && !rst;
  assign deq_fire = bus.deq_valid && bus.deq_ready;

  // Bypass only when nothing older sits in the SRAM or in flight, which
  // keeps FIFO order intact.
  assign bypass = enq_fire && (sram_cnt_q == '0) && !inflight_q && (obuf_cnt_q != 2'd2);
  assign wr     = enq_fire && !bypass;

  // Prefetch whenever the output buffer will have room for the returning
  // word, counting the in-flight read and this cycle's pop.
  assign occ = obuf_cnt_q + {1'b0, inflight_q};
  assign rd  = (sram_cnt_q != '0) && (deq_fire ? (occ <= 2'd2) : (occ <= 2'd1));

  // Retire and bypass are mutually exclusive (bypass needs inflight==0).
  assign push      = inflight_q || bypass;
  assign push_data = inflight_q ? bus.sram_read_data : bus.enq_data;
  assign tail      = head_q ^ obuf_cnt_q[0];

  assign bus.sram_write_en   = wr;
  assign bus.sram_write_addr = wr_ptr_q;
  assign bus.sram_write_data = bus.enq_data;
  assign bus.sram_read_en    = rd;
  assign bus.sram_read_addr  = rd_ptr_q;

  assign bus.count = sram_cnt_q + {{ADDR_W{1'b0}}, inflight_q}
                     + {{(ADDR_W-1){1'b0}}, obuf_cnt_q};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    inflight_d = rd;
    obuf_d     = obuf_q;
    head_d     = head_q;
    obuf_cnt_d = obuf_cnt_q;
    if (wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    sram_cnt_d = sram_cnt_q + {{ADDR_W{1'b0}}, wr} - {{ADDR_W{1'b0}}, rd};
    if (push) begin
      obuf_d[tail] = push_data;
    end
    if (deq_fire) begin
      head_d = ~head_q;
    end
    obuf_cnt_d = obuf_cnt_q + {1'b0, push} - {1'b0, deq_fire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      obuf_q[0]  <= '0;
      obuf_q[1]  <= '0;
      head_q     <= 1'b0;
      obuf_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      obuf_q     <= obuf_d;
      head_q     <= head_d;
      obuf_cnt_q <= obuf_cnt_d;
    end
  end
endmodule

// File: tb/tb_sram_fifo_64x2.sv
module tb_sram_fifo_64x2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_fifo_64x2_if #(.ADDR_W(6), .DATA_W(2)) bus ();

  sram_fifo_64x2 #(.DEPTH(64), .ADDR_W(6), .DATA_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM wrapper model: 64x2, one-cycle registered read.
  logic [1:0] mem [64];
  logic [1:0] rdata = 2'b00;
  always @(posedge clk) begin
    if (bus.sram_read_en) rdata <= mem[bus.sram_read_addr];
    if (bus.sram_write_en) mem[bus.sram_write_addr] <= bus.sram_write_data;
  end
  assign bus.sram_read_data = rdata;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: the FIFO contents in order, plus expected SRAM pointers.
  logic [1:0] q[$];
  logic [5:0] exp_wa = '0;
  logic [5:0] exp_ra = '0;
  int n_writes = 0;

  // Sample handshakes just before the edge, then advance the model.
  task automatic tick();
    bit ef, df, we, re;
    logic [1:0] ed;
    ef = bus.enq_valid && bus.enq_ready;
    df = bus.deq_valid && bus.deq_ready;
    ed = bus.enq_data;
    we = bus.sram_write_en;
    re = bus.sram_read_en;
    @(posedge clk);
    if (df && q.size() > 0) void'(q.pop_front());
    if (ef) q.push_back(ed);
    if (we) begin exp_wa++; n_writes++; end
    if (re) exp_ra++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.enq_valid = 1'b1; bus.enq_data = 2'b11; bus.deq_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (bus.enq_ready !== 1'b1) begin n_err++; $display("FAIL rst_enq_ready got=%b exp=1", bus.enq_ready); end
    n_chk++; if (bus.deq_valid !== 1'b0) begin n_err++; $display("FAIL rst_deq_valid got=%b exp=0", bus.deq_valid); end
    n_chk++; if (bus.count !== 7'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    n_chk++; if (bus.sram_write_en !== 1'b0) begin n_err++; $display("FAIL rst_write_en got=%b exp=0", bus.sram_write_en); end
    n_chk++; if (bus.sram_read_en !== 1'b0) begin n_err++; $display("FAIL rst_read_en got=%b exp=0", bus.sram_read_en); end
    n_chk++; if (bus.sram_write_addr !== 6'd0 || bus.sram_read_addr !== 6'd0) begin
      n_err++; $display("FAIL rst_addr got=%0d/%0d exp=0/0", bus.sram_write_addr, bus.sram_read_addr); end
    bus.enq_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete(); exp_wa = '0; exp_ra = '0; n_writes = 0;
  endtask

  task automatic test_bypass();
    bus.enq_valid = 1'b1; bus.enq_data = 2'b10; bus.deq_ready = 1'b1;
    #1;
    n_chk++; if (bus.sram_write_en !== 1'b0) begin n_err++; $display("FAIL byp_no_write got=%b exp=0", bus.sram_write_en); end
    tick();
    bus.enq_valid = 1'b0;
    #1;
    n_chk++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== 2'b10) begin
      n_err++; $display("FAIL byp_deq got=%b/%b exp=1/10", bus.deq_valid, bus.deq_data); end
    n_chk++; if (bus.count !== 7'd1) begin n_err++; $display("FAIL byp_count1 got=%0d exp=1", bus.count); end
    tick(); #1;
    n_chk++; if (bus.count !== 7'd0 || bus.deq_valid !== 1'b0) begin
      n_err++; $display("FAIL byp_empty got=%0d/%b exp=0/0", bus.count, bus.deq_valid); end
  endtask

  task automatic test_fill();
    int acc = 0;
    int cyc = 0;
    bus.deq_ready = 1'b0;
    while (acc < 66 && cyc < 200) begin
      bus.enq_valid = 1'b1; bus.enq_data = 2'(acc % 4);
      #1;
      if (bus.sram_write_en) begin
        n_chk++; if (bus.sram_write_addr !== exp_wa) begin
          n_err++; $display("FAIL fill_waddr got=%0d exp=%0d", bus.sram_write_addr, exp_wa); end
      end
      if (bus.enq_ready) acc++;
      tick();
      cyc++;
    end
    n_chk++; if (acc != 66) begin n_err++; $display("FAIL fill_timeout got=%0d exp=66", acc); end
    #1;
    n_chk++; if (bus.enq_ready !== 1'b0) begin n_err++; $display("FAIL fill_enq_ready got=%b exp=0", bus.enq_ready); end
    n_chk++; if (bus.count !== 7'd66) begin n_err++; $display("FAIL fill_count got=%0d exp=66", bus.count); end
    n_chk++; if (n_writes != 64) begin n_err++; $display("FAIL fill_writes got=%0d exp=64", n_writes); end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_chk++; if (bus.count !== 7'd66 || bus.sram_write_en !== 1'b0) begin
        n_err++; $display("FAIL fill_hold got=%0d/%b exp=66/0", bus.count, bus.sram_write_en); end
    end
  endtask

  task automatic test_full_simul();
    bus.enq_valid = 1'b1; bus.enq_data = 2'b11; bus.deq_ready = 1'b1;
    #1;
    n_chk++; if (bus.enq_ready !== 1'b0) begin n_err++; $display("FAIL simul_enq_ready got=%b exp=0", bus.enq_ready); end
    n_chk++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== q[0]) begin
      n_err++; $display("FAIL simul_deq got=%b/%b exp=1/%b", bus.deq_valid, bus.deq_data, q[0]); end
    tick();
    bus.enq_valid = 1'b0;
    #1;
    n_chk++; if (bus.count !== 7'd65) begin n_err++; $display("FAIL simul_count got=%0d exp=65", bus.count); end
    n_chk++; if (bus.enq_ready !== 1'b1) begin n_err++; $display("FAIL simul_reopen got=%b exp=1", bus.enq_ready); end
  endtask

  task automatic test_drain();
    int cyc = 0;
    bus.enq_valid = 1'b0; bus.deq_ready = 1'b1;
    while (q.size() > 0 && cyc < 100) begin
      #1;
      n_chk++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== q[0]) begin
        n_err++; $display("FAIL drain_data got=%b/%b exp=1/%b", bus.deq_valid, bus.deq_data, q[0]); end
      n_chk++; if (bus.count !== 7'(q.size())) begin
        n_err++; $display("FAIL drain_count got=%0d exp=%0d", bus.count, q.size()); end
      tick();
      cyc++;
    end
    #1;
    n_chk++; if (q.size() != 0) begin n_err++; $display("FAIL drain_timeout got=%0d exp=0", q.size()); end
    n_chk++; if (bus.deq_valid !== 1'b0 || bus.count !== 7'd0) begin
      n_err++; $display("FAIL drain_empty got=%b/%0d exp=0/0", bus.deq_valid, bus.count); end
  endtask

  task automatic test_random();
    bit saw_wrap = 0;
    int cyc = 0;
    for (int i = 0; i < 200; i++) begin
      bus.enq_valid = ($urandom_range(0, 9) != 0);
      bus.enq_data  = 2'($urandom);
      bus.deq_ready = $urandom_range(0, 1) == 1;
      #1;
      if (bus.deq_valid && bus.deq_ready) begin
        n_chk++; if (q.size() == 0 || bus.deq_data !== q[0]) begin
          n_err++; $display("FAIL rnd_data got=%b exp=%b size=%0d", bus.deq_data, (q.size() > 0) ? q[0] : 2'bxx, q.size()); end
      end
      n_chk++; if (bus.count !== 7'(q.size())) begin
        n_err++; $display("FAIL rnd_count got=%0d exp=%0d", bus.count, q.size()); end
      if (bus.sram_write_en) begin
        n_chk++; if (bus.sram_write_addr !== exp_wa) begin
          n_err++; $display("FAIL rnd_waddr got=%0d exp=%0d", bus.sram_write_addr, exp_wa); end
        if (exp_wa == 6'd63) saw_wrap = 1;
      end
      if (bus.sram_read_en) begin
        n_chk++; if (bus.sram_read_addr !== exp_ra) begin
          n_err++; $display("FAIL rnd_raddr got=%0d exp=%0d", bus.sram_read_addr, exp_ra); end
      end
      if (bus.sram_write_en && bus.sram_read_en) begin
        n_chk++; if (bus.sram_write_addr === bus.sram_read_addr) begin
          n_err++; $display("FAIL rnd_collide got=%0d exp=distinct", bus.sram_write_addr); end
      end
      tick();
    end
    n_chk++; if (!saw_wrap) begin n_err++; $display("FAIL rnd_wrap got=0 exp=1"); end
    bus.enq_valid = 1'b0; bus.deq_ready = 1'b1;
    while (q.size() > 0 && cyc < 200) begin
      #1;
      if (bus.deq_valid) begin
        n_chk++; if (bus.deq_data !== q[0]) begin
          n_err++; $display("FAIL rnd_drain got=%b exp=%b", bus.deq_data, q[0]); end
      end
      tick();
      cyc++;
    end
    #1;
    n_chk++; if (q.size() != 0 || bus.count !== 7'd0) begin
      n_err++; $display("FAIL rnd_end got=%0d/%0d exp=0/0", q.size(), bus.count); end
  endtask

  task automatic test_reset_mid();
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.enq_valid = 1'b1; bus.enq_data = 2'(i % 3 + 1);
      #1; tick();
    end
    bus.enq_valid = 1'b0; bus.deq_ready = 1'b1;
    #1;
    n_chk++; if (bus.sram_read_en !== 1'b1) begin n_err++; $display("FAIL mid_read_issue got=%b exp=1", bus.sram_read_en); end
    tick();
    // A read is now in flight; reset mid-cycle.
    bus.deq_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_chk++; if (bus.deq_valid !== 1'b0 || bus.count !== 7'd0 || bus.enq_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_out got=%b/%0d/%b exp=0/0/1", bus.deq_valid, bus.count, bus.enq_ready); end
    n_chk++; if (bus.sram_read_en !== 1'b0 || bus.sram_write_en !== 1'b0 || bus.sram_read_addr !== 6'd0) begin
      n_err++; $display("FAIL mid_rst_sram got=%b/%b/%0d exp=0/0/0", bus.sram_read_en, bus.sram_write_en, bus.sram_read_addr); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete(); exp_wa = '0; exp_ra = '0; n_writes = 0;
    bus.enq_valid = 1'b1; bus.enq_data = 2'b01; bus.deq_ready = 1'b1;
    #1;
    n_chk++; if (bus.sram_write_en !== 1'b0) begin n_err++; $display("FAIL mid_byp got=%b exp=0", bus.sram_write_en); end
    tick();
    bus.enq_valid = 1'b0;
    #1;
    n_chk++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== 2'b01 || bus.count !== 7'd1) begin
      n_err++; $display("FAIL mid_deq got=%b/%b/%0d exp=1/01/1", bus.deq_valid, bus.deq_data, bus.count); end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_chk++; if (bus.deq_valid !== 1'b0 || bus.count !== 7'd0) begin
        n_err++; $display("FAIL mid_stale got=%b/%0d exp=0/0", bus.deq_valid, bus.count); end
    end
  endtask

  initial begin
    bus.enq_valid = 1'b0; bus.enq_data = 2'b00; bus.deq_ready = 1'b0;
    test_reset();
    test_bypass();
    test_fill();
    test_full_simul();
    test_drain();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_fifo_64x2.md
# sram_fifo_64x2

Synchronous FIFO controller that drives an external 1R1W SRAM macro wrapper (64 entries x 2 bits, one-cycle registered read) as its storage, and presents valid/ready enqueue and dequeue ports to the surrounding BSV-generated logic. It is the initiator side of the SRAM interface: it issues all writes and reads and absorbs the read latency with a 2-entry output buffer, so sustained throughput is one element per cycle. Total capacity is DEPTH + 2 elements.

## Interface
- DEPTH, 64, SRAM entries; power of two
- ADDR_W, 6, SRAM address width, log2(DEPTH)
- DATA_W, 2, element width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- enq_valid  in  1  producer offers enq_data
- enq_ready  out  1  FIFO accepts; enq fires when enq_valid && enq_ready
- enq_data  in  DATA_W  element to enqueue
- deq_valid  out  1  deq_data holds the oldest element
- deq_ready  in  1  consumer takes; deq fires when deq_valid && deq_ready
- deq_data  out  DATA_W  oldest element
- count  out  ADDR_W+1  elements held (SRAM + in-flight read + output buffer), 0..DEPTH+2
- sram_write_en  out  1  SRAM write strobe
- sram_write_addr  out  ADDR_W  write address
- sram_write_data  out  DATA_W  write data
- sram_read_en  out  1  SRAM read strobe
- sram_read_addr  out  ADDR_W  read address
- sram_read_data  in  DATA_W  read data, valid the cycle after sram_read_en

## Operation
- State: wr_ptr, rd_ptr (ADDR_W, wrap modulo DEPTH), sram_cnt (0..DEPTH), inflight (1 bit), obuf (2 entries, head/tail, obuf_cnt 0..2).
- enq_ready = (sram_cnt < DEPTH); depends on state only, never on deq_ready.
- Bypass: enq fire with sram_cnt==0, inflight==0, obuf_cnt<2 (start-of-cycle values) writes enq_data straight into obuf tail; no SRAM write.
- Otherwise enq fire: sram_write_en=1, addr=wr_ptr, data=enq_data; wr_ptr++, sram_cnt++.
- Prefetch: sram_read_en=1 iff sram_cnt>0 && (obuf_cnt + inflight - deq_fire) < 2; addr=rd_ptr; rd_ptr++, sram_cnt--, inflight<=1. sram_read_en combinationally depends on deq_ready.
- Retire: if inflight, sram_read_data pushed into obuf tail at the cycle end; inflight cleared unless a new read issues the same cycle.
- deq_valid = (obuf_cnt>0); deq_data = obuf head; deq fire pops head.
- Same-cycle enq+deq, bypass+deq, retire+deq all legal; obuf_cnt updates by net push/pop.
- Read never targets an address written the same cycle: read requires sram_cnt>0 pre-write, write requires sram_cnt<DEPTH, so rd_ptr==wr_ptr cannot coincide with both.
- count = sram_cnt + inflight + obuf_cnt; sram_cnt update: +write -read.
- Ordering: bypass only when SRAM and in-flight empty, so FIFO order is strictly preserved.

## Timing
- Reset (async assert, sync release): pointers, sram_cnt, inflight, obuf_cnt = 0; deq_valid=0, count=0, sram_write_en=0, sram_read_en=0, addresses 0, enq_ready=1 (also during reset). SRAM contents are not cleared; reset mid-operation discards all held and in-flight data, late read data is ignored.
- Empty FIFO, enq at cycle t: deq_valid=1 at t+1 (bypass).
- Element written to SRAM at t: read issued earliest t+1, data on sram_read_data t+2, in obuf, deq_valid at t+3.
- Steady state with deq_ready=1 and sram_cnt>0: one read and one deq per cycle.
- Full: count=DEPTH+2, enq_ready=0; one deq frees SRAM space via prefetch, enq_ready=1 the cycle after the read issues.
- Pointer wrap: 63 -> 0 with no bubble.

## Test plan
- Reset then single enq of 2'b10 at cycle 1, deq_ready=1 -> deq_valid=1 at cycle 2, deq_data=2'b10, count 1 -> 0, no SRAM write.
- Enq 66 elements (value i mod 4) with deq_ready=0 -> enq_ready drops after 66th accept, count=66; sram_write_en exactly 64 times, addresses 0..63; enq_valid held high is not accepted.
- From full, deq_ready=1 continuously -> 66 elements out in enq order, one per cycle after first, count reaches 0, deq_valid falls.
- Continuous enq and deq for 200 cycles with random deq_ready -> output sequence equals input, no loss/duplicate, pointers wrap past 63, never read and write same address in one cycle.
- Fill 10 elements, assert rst mid-stream with a read in flight -> all outputs at reset values immediately; after release, enq of 2'b01 appears at deq next cycle, stale read data never surfaces.
- Simultaneous enq and deq with count=DEPTH+2 -> enq refused (enq_ready=0), deq fires, count=65.
